rd_fifo_status_ctrl: RTL and testbench
======================================

RD_FIFO_STATUS_CTRL -- requirements
Module: rd_fifo_status_ctrl

Interface
REQ-001 SHALL have parameter THRESHOLD, default 400: FIFO fill level at or below which a read burst may launch.
REQ-002 SHALL have parameter BURST_LEN, default 100: full burst length in words.
REQ-003 SHALL have parameter LSIZE, default 9: width of req_len.
REQ-004 SHALL have parameter DEPTH, default 1024: FIFO capacity in words.
REQ-005 SHALL have parameter TIMEOUT, default 24'hFFF000: cycles allowed per request before error.
REQ-006 SHALL have port clock, input, 1: the only clock.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port enable, input, 1: permits new bursts.
REQ-009 SHALL have port frame_start, input, 1: one-cycle pulse that loads frame_len.
REQ-010 SHALL have port frame_len, input, 24: words in the coming frame.
REQ-011 SHALL have port count, input, 10: FIFO fill level.
REQ-012 SHALL have port fifo_empty, input, 1: FIFO empty flag.
REQ-013 SHALL have port burst_req, output, 1: read request to the AXI read master.
REQ-014 SHALL have port req_len, output, LSIZE: length of the current request.
REQ-015 SHALL have port resp, input, 1: master accepted the request.
REQ-016 SHALL have port done, input, 1: master finished writing the burst into the FIFO.
REQ-017 SHALL have port burst_done, output, 1: one-cycle pulse per completed burst.
REQ-018 SHALL have port frame_done, output, 1: one-cycle pulse when the last burst of a frame completes.
REQ-019 SHALL have port rst_chain, output, 1: one-cycle pulse on timeout, used to flush the FIFO and master.
REQ-020 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-021 SHALL have states IDLE, REQ, WAIT_DONE, FSH, FRAME_END, TIME_ERR and RESET_CHAIN.
REQ-022 SHALL keep a 24-bit remaining-word counter rem, loaded with frame_len on frame_start in any state.
REQ-023 SHALL compute next_len = min(BURST_LEN, rem), truncated to LSIZE bits.
REQ-024 SHALL move IDLE->REQ when enable=1, rem!=0, count<=THRESHOLD and (DEPTH-count)>=next_len; otherwise it SHALL stay in IDLE.
REQ-025 SHALL register req_len<=next_len on entry to REQ and hold req_len stable until the next entry to REQ.
REQ-026 SHALL register burst_req high while the next state is REQ, so the output is registered and follows the state one cycle later.
REQ-027 SHALL move REQ->WAIT_DONE on resp=1 and decrement rem by req_len in that same cycle.
REQ-028 SHALL move WAIT_DONE->FSH on done=1.
REQ-029 SHALL move FSH->FRAME_END if rem==0, else FSH->IDLE; FRAME_END->IDLE unconditionally.
REQ-030 SHALL pulse burst_done for one cycle when the next state is FSH, and pulse frame_done for one cycle when the next state is FRAME_END.
REQ-031 SHALL clear the timeout counter in IDLE, increment it in REQ and WAIT_DONE saturating at its maximum, and move to TIME_ERR when it reaches TIMEOUT; timeout SHALL take priority over resp and done.
REQ-032 SHALL move TIME_ERR->RESET_CHAIN, pulse rst_chain when the next state is TIME_ERR, clear rem to 0, and move RESET_CHAIN->IDLE only when fifo_empty=1.
REQ-033 SHALL ignore resp outside REQ and done outside WAIT_DONE.
REQ-034 SHALL ignore a frame_start coinciding with resp in favour of the load: rem<=frame_len with no decrement.
REQ-035 SHALL, when enable deasserts mid-burst, complete the current burst and launch no new burst.
REQ-036 SHALL give a minimum latency of 1 cycle from the qualifying IDLE cycle to burst_req=1.

Reset
REQ-037 SHALL on rst=1, synchronously at the clock edge, force state=IDLE, rem=0, req_len=0, timeout counter=0, and burst_req, burst_done, frame_done, rst_chain=0.
REQ-038 SHALL, on rst asserted mid-burst, abandon the burst without a done pulse; the master is reset by the same rst.

Structure
REQ-039 SHALL place the state encoding localparams and the 24-bit frame-counter width in a shared package, vdma_rd_pkg.
REQ-040 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-041 SHALL cover this scenario: frame_len=250, count=0, resp and done one cycle after each request -> req_len 100, 100, 50; three burst_done pulses; frame_done after the third.
REQ-042 SHALL cover this scenario: count=950 with next_len=100 -> no burst_req; lowering count to 400 -> burst_req within 2 cycles.
REQ-043 SHALL cover this scenario: resp withheld for TIMEOUT cycles -> one rst_chain pulse; state held in RESET_CHAIN until fifo_empty=1; rem=0.
REQ-044 SHALL cover this scenario: frame_start with frame_len=300 in the same cycle as resp -> rem=300.
REQ-045 SHALL cover this scenario: rst during WAIT_DONE -> all outputs 0 the next cycle; a later done is ignored.
REQ-046 SHALL cover this scenario: enable=0 after the first resp with frame_len=500 -> the burst completes with burst_done, then no further burst_req.

Source files
------------

// File: rtl/vdma_rd_pkg.sv
// ============================================================================
// Module      : vdma_rd_pkg
// Description : Shared state encoding and frame-counter width for the VDMA
//               read-side burst controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vdma_rd_pkg;

    localparam int FRAME_W = 24;
    localparam int ST_W    = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE        = 3'd0;
    localparam state_t ST_REQ         = 3'd1;
    localparam state_t ST_WAIT_DONE   = 3'd2;
    localparam state_t ST_FSH         = 3'd3;
    localparam state_t ST_FRAME_END   = 3'd4;
    localparam state_t ST_TIME_ERR    = 3'd5;
    localparam state_t ST_RESET_CHAIN = 3'd6;

endpackage

`default_nettype wire

// File: rtl/rd_fifo_status_ctrl.sv
// ============================================================================
// Module      : rd_fifo_status_ctrl
// Description : Launches AXI read bursts into a FIFO based on its fill level,
//               tracks frame progress and recovers from stalled requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_fifo_status_ctrl
    import vdma_rd_pkg::*;
#(
    parameter int          THRESHOLD = 400,
    parameter int          BURST_LEN = 100,
    parameter int          LSIZE     = 9,
    parameter int          DEPTH     = 1024,
    parameter logic [23:0] TIMEOUT   = 24'hFFF000
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_start,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic [9:0]         count,
    input  logic               fifo_empty,
    output logic               burst_req,
    output logic [LSIZE-1:0]   req_len,
    input  logic               resp,
    input  logic               done,
    output logic               burst_done,
    output logic               frame_done,
    output logic               rst_chain,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] rem_q, rem_d;
    logic [LSIZE-1:0]   req_len_q, req_len_d;
    logic [23:0]        tmo_q, tmo_d;
    logic               burst_req_q, burst_req_d;
    logic               burst_done_q, burst_done_d;
    logic               frame_done_q, frame_done_d;
    logic               rst_chain_q, rst_chain_d;

    logic [FRAME_W-1:0] w_rem_min;
    logic [LSIZE-1:0]   w_next_len;
    logic [31:0]        w_space;
    logic               w_launch;
    logic [23:0]        w_tmo_inc;
    logic               w_tmo_hit;

    assign w_rem_min  = (rem_q < FRAME_W'(BURST_LEN)) ? rem_q : FRAME_W'(BURST_LEN);
    assign w_next_len = LSIZE'(w_rem_min);
    assign w_space    = 32'(DEPTH) - 32'(count);
    assign w_launch   = enable && (rem_q != '0)
                        && (32'(count) <= 32'(THRESHOLD))
                        && (w_space >= 32'(w_next_len));

    // The stall counter saturates so a huge TIMEOUT can never wrap back to zero.
    assign w_tmo_inc  = (tmo_q == 24'hFFFFFF) ? tmo_q : tmo_q + 24'd1;
    assign w_tmo_hit  = (w_tmo_inc >= TIMEOUT);

    // State register and registered outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            req_len_q    <= '0;
            tmo_q        <= '0;
            burst_req_q  <= 1'b0;
            burst_done_q <= 1'b0;
            frame_done_q <= 1'b0;
            rst_chain_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            req_len_q    <= req_len_d;
            tmo_q        <= tmo_d;
            burst_req_q  <= burst_req_d;
            burst_done_q <= burst_done_d;
            frame_done_q <= frame_done_d;
            rst_chain_q  <= rst_chain_d;
        end
    end

    // Next-state logic; the stall timeout outranks resp and done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_launch) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (w_tmo_hit)  state_d = ST_TIME_ERR;
                else if (resp)  state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_tmo_hit)  state_d = ST_TIME_ERR;
                else if (done)  state_d = ST_FSH;
            end
            ST_FSH: begin
                state_d = (rem_q == '0) ? ST_FRAME_END : ST_IDLE;
            end
            ST_FRAME_END:   state_d = ST_IDLE;
            ST_TIME_ERR:    state_d = ST_RESET_CHAIN;
            ST_RESET_CHAIN: begin
                if (fifo_empty) state_d = ST_IDLE;
            end
            default:        state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        burst_req_d  = (state_d == ST_REQ);
        burst_done_d = (state_d == ST_FSH);
        frame_done_d = (state_d == ST_FRAME_END);
        rst_chain_d  = (state_d == ST_TIME_ERR);

        req_len_d = req_len_q;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) req_len_d = w_next_len;

        tmo_d = tmo_q;
        if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if ((state_q == ST_REQ) || (state_q == ST_WAIT_DONE)) begin
            tmo_d = w_tmo_inc;
        end

        // A new frame load wins over the accepted-request decrement.
        rem_d = rem_q;
        if (frame_start) begin
            rem_d = frame_len;
        end else if (state_q == ST_TIME_ERR) begin
            rem_d = '0;
        end else if ((state_q == ST_REQ) && (state_d == ST_WAIT_DONE)) begin
            rem_d = (rem_q >= FRAME_W'(req_len_q)) ? rem_q - FRAME_W'(req_len_q) : '0;
        end
    end

    assign burst_req  = burst_req_q;
    assign req_len    = req_len_q;
    assign burst_done = burst_done_q;
    assign frame_done = frame_done_q;
    assign rst_chain  = rst_chain_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rd_fifo_status_ctrl.sv
// ============================================================================
// Module      : tb_rd_fifo_status_ctrl
// Description : Directed self-checking bench for rd_fifo_status_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rd_fifo_status_ctrl;

    localparam int          LSIZE   = 9;
    localparam logic [23:0] TIMEOUT = 24'd20;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             frame_start = 1'b0;
    logic [23:0]      frame_len = '0;
    logic [9:0]       count = '0;
    logic             fifo_empty = 1'b0;
    logic             burst_req;
    logic [LSIZE-1:0] req_len;
    logic             resp = 1'b0;
    logic             done = 1'b0;
    logic             burst_done;
    logic             frame_done;
    logic             rst_chain;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    rd_fifo_status_ctrl #(
        .THRESHOLD (400),
        .BURST_LEN (100),
        .LSIZE     (LSIZE),
        .DEPTH     (1024),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .enable      (enable),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .count       (count),
        .fifo_empty  (fifo_empty),
        .burst_req   (burst_req),
        .req_len     (req_len),
        .resp        (resp),
        .done        (done),
        .burst_done  (burst_done),
        .frame_done  (frame_done),
        .rst_chain   (rst_chain),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b1; resp = 1'b0; done = 1'b0; frame_start = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic frame_pulse(input logic [23:0] len);
        frame_start = 1'b1; frame_len = len;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_req(input int max, output logic found, output int cyc);
        cyc = 0;
        while (!burst_req && cyc < max) begin
            tick();
            cyc++;
        end
        found = burst_req;
    endtask

    task automatic no_req_for(input string tag, input int n);
        logic seen = 1'b0;
        logic bz = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen |= burst_req;
            bz   |= busy;
        end
        check({tag, "_noreq"}, 32'(seen), 0);
        check({tag, "_idle"}, 32'(bz), 0);
    endtask

    // One full request/response/done handshake with resp and done one cycle apart.
    task automatic do_burst(input string tag, input int exp_len, input logic exp_fd,
                            input logic reload, input logic [23:0] reload_len,
                            input logic drop_en);
        logic found;
        int   cyc;
        wait_req(8, found, cyc);
        check({tag, "_req_seen"}, 32'(found), 1);
        check({tag, "_req_len"}, 32'(req_len), 32'(exp_len));
        resp = 1'b1;
        if (reload) begin
            frame_start = 1'b1; frame_len = reload_len;
        end
        tick();
        resp = 1'b0; frame_start = 1'b0;
        if (drop_en) enable = 1'b0;
        check({tag, "_req_drop"}, 32'(burst_req), 0);
        check({tag, "_busy"}, 32'(busy), 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check({tag, "_bdone"}, 32'(burst_done), 1);
        check({tag, "_fdone_early"}, 32'(frame_done), 0);
        tick();
        check({tag, "_bdone_pulse"}, 32'(burst_done), 0);
        check({tag, "_fdone"}, 32'(frame_done), 32'(exp_fd));
    endtask

    initial begin
        logic found;
        int   cyc;
        int   hold;

        // Reset state
        tick(); tick();
        check("rst_burst_req", 32'(burst_req), 0);
        check("rst_req_len", 32'(req_len), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_outs", {29'd0, burst_done, frame_done, rst_chain}, 0);
        rst = 1'b0;

        // 250-word frame: 100, 100, 50 with frame_done on the last
        enable = 1'b1; count = 10'd0;
        frame_pulse(24'd250);
        do_burst("f250_b1", 100, 1'b0, 1'b0, 24'd0, 1'b0);
        do_burst("f250_b2", 100, 1'b0, 1'b0, 24'd0, 1'b0);
        do_burst("f250_b3", 50, 1'b1, 1'b0, 24'd0, 1'b0);
        no_req_for("f250_after", 6);

        // Fill-level gating and threshold boundary
        do_reset();
        count = 10'd950;
        frame_pulse(24'd250);
        no_req_for("cnt950", 8);
        count = 10'd401;
        no_req_for("cnt401", 5);
        count = 10'd400;
        wait_req(4, found, cyc);
        check("cnt400_found", 32'(found), 1);
        check("cnt400_latency", 32'(cyc), 1);
        do_burst("cnt400_b1", 100, 1'b0, 1'b0, 24'd0, 1'b0);
        do_burst("cnt400_b2", 100, 1'b0, 1'b0, 24'd0, 1'b0);
        do_burst("cnt400_b3", 50, 1'b1, 1'b0, 24'd0, 1'b0);

        // Stalled request -> timeout and flush handshake
        do_reset();
        count = 10'd0; fifo_empty = 1'b0;
        frame_pulse(24'd250);
        wait_req(8, found, cyc);
        check("tmo_req_seen", 32'(found), 1);
        hold = 0;
        while (!rst_chain && hold < 100) begin
            if (burst_req) hold++;
            tick();
        end
        check("tmo_chain_seen", 32'(rst_chain), 1);
        check("tmo_req_cycles", 32'(hold), 32'(TIMEOUT));
        check("tmo_req_low", 32'(burst_req), 0);
        tick();
        check("tmo_chain_pulse", 32'(rst_chain), 0);
        for (int i = 0; i < 4; i++) tick();
        check("tmo_hold_busy", 32'(busy), 1);
        check("tmo_hold_chain", 32'(rst_chain), 0);
        fifo_empty = 1'b1;
        tick();
        check("tmo_release", 32'(busy), 0);
        no_req_for("tmo_rem0", 6);
        fifo_empty = 1'b0;

        // frame_start coinciding with resp: reload wins, no decrement
        do_reset();
        frame_pulse(24'd250);
        do_burst("rl_b0", 100, 1'b0, 1'b1, 24'd300, 1'b0);
        do_burst("rl_b1", 100, 1'b0, 1'b0, 24'd0, 1'b0);
        do_burst("rl_b2", 100, 1'b0, 1'b0, 24'd0, 1'b0);
        do_burst("rl_b3", 100, 1'b1, 1'b0, 24'd0, 1'b0);

        // Reset while waiting for done
        do_reset();
        frame_pulse(24'd250);
        wait_req(8, found, cyc);
        check("wr_req_seen", 32'(found), 1);
        resp = 1'b1;
        tick();
        resp = 1'b0;
        check("wr_in_wait", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wr_outs", {27'd0, burst_req, burst_done, frame_done, rst_chain, busy}, 0);
        check("wr_req_len", 32'(req_len), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wr_done_ignored", 32'(burst_done), 0);
        no_req_for("wr_after", 5);

        // enable dropped after first resp: burst completes, nothing new
        do_reset();
        enable = 1'b1;
        frame_pulse(24'd500);
        do_burst("en_b1", 100, 1'b0, 1'b0, 24'd0, 1'b1);
        no_req_for("en_off", 10);
        enable = 1'b1;
        wait_req(4, found, cyc);
        check("en_resume", 32'(found), 1);
        check("en_resume_len", 32'(req_len), 100);

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
